// File: rtl/operand_fetch_if.sv
// Bundle of the operand-fetch handshakes: decoded-instruction input, register-file
// read port, write-back snoop, and the registered operand bundle with the scoreboard.
interface operand_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_rd_en;
  logic [31:0] in_tag;

  logic [4:0]  readAddressA;
  logic [4:0]  readAddressB;
  logic [31:0] readDataA;
  logic [31:0] readDataB;

  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [4:0]  out_rd;
  logic        out_rd_en;
  logic [31:0] out_tag;
  logic [31:0] sb_busy;

  // master: the surrounding pipeline / register file; slave: operand_fetch itself
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_en, in_tag,
    output readDataA, readDataB,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready, readAddressA, readAddressB,
    input  out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_en, out_tag, sb_busy
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_en, in_tag,
    input  readDataA, readDataB,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready, readAddressA, readAddressB,
    output out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_en, out_tag, sb_busy
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file with write-back bypass, tracks pending
// writes in a scoreboard, and presents a one-entry registered operand bundle.
module operand_fetch (
  input  logic          clk,
  input  logic          reset,
  operand_fetch_if.slave bus
);

  logic [31:0] sb_busy_q, sb_busy_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_rs1_data_q, out_rs1_data_d;
  logic [31:0] out_rs2_data_q, out_rs2_data_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_rd_en_q, out_rd_en_d;
  logic [31:0] out_tag_q, out_tag_d;

  logic [31:0] wb_clr;
  logic [31:0] rd_set;
  logic [31:0] busy_eff;
  logic        hazard;
  logic        can_advance;
  logic        accept;
  logic [31:0] op_a;
  logic [31:0] op_b;

  function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] rdata,
                                          input logic wen, input logic [4:0] waddr,
                                          input logic [31:0] wdata);
    logic [31:0] r;
    r = rdata;
    if (rs == 5'd0)
      r = 32'd0;
    else if (wen && (waddr == rs))
      r = wdata;
    return r;
  endfunction

  // busy_eff excludes registers whose write-back lands this cycle; x0 is never pending
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
        assign wb_clr[gi]    = 1'b0;
        assign rd_set[gi]    = 1'b0;
        assign busy_eff[gi]  = 1'b0;
        assign sb_busy_d[gi] = 1'b0;
      end else begin : g_xn
        assign wb_clr[gi]    = bus.wb_en && (bus.wb_addr == 5'(gi));
        assign rd_set[gi]    = accept && bus.in_rd_en && (bus.in_rd == 5'(gi));
        assign busy_eff[gi]  = sb_busy_q[gi] && !wb_clr[gi];
        assign sb_busy_d[gi] = rd_set[gi] || busy_eff[gi];
      end
    end
  endgenerate

  assign hazard = bus.in_valid &&
                  (busy_eff[bus.in_rs1] || busy_eff[bus.in_rs2] ||
                   (bus.in_rd_en && busy_eff[bus.in_rd]));

  assign can_advance = !out_valid_q || bus.out_ready;
  assign accept      = bus.in_valid && bus.in_ready;

  assign op_a = resolve(bus.in_rs1, bus.readDataA, bus.wb_en, bus.wb_addr, bus.wb_data);
  assign op_b = resolve(bus.in_rs2, bus.readDataB, bus.wb_en, bus.wb_addr, bus.wb_data);

  always_comb begin
    out_valid_d    = out_valid_q;
    out_rs1_data_d = out_rs1_data_q;
    out_rs2_data_d = out_rs2_data_q;
    out_rd_d       = out_rd_q;
    out_rd_en_d    = out_rd_en_q;
    out_tag_d      = out_tag_q;
    if (can_advance) begin
      out_valid_d = accept;
      if (accept) begin
        out_rs1_data_d = op_a;
        out_rs2_data_d = op_b;
        out_rd_d       = bus.in_rd;
        out_rd_en_d    = bus.in_rd_en;
        out_tag_d      = bus.in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_busy_q      <= '0;
      out_valid_q    <= 1'b0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
      out_rd_q       <= '0;
      out_rd_en_q    <= 1'b0;
      out_tag_q      <= '0;
    end else begin
      sb_busy_q      <= sb_busy_d;
      out_valid_q    <= out_valid_d;
      out_rs1_data_q <= out_rs1_data_d;
      out_rs2_data_q <= out_rs2_data_d;
      out_rd_q       <= out_rd_d;
      out_rd_en_q    <= out_rd_en_d;
      out_tag_q      <= out_tag_d;
    end
  end

  // reset gates in_ready directly so nothing is accepted while it is held
  assign bus.in_ready     = can_advance && !hazard && !reset;
  assign bus.readAddressA = bus.in_rs1;
  assign bus.readAddressB = bus.in_rs2;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rs1_data = out_rs1_data_q;
  assign bus.out_rs2_data = out_rs2_data_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_rd_en    = out_rd_en_q;
  assign bus.out_tag      = out_tag_q;
  assign bus.sb_busy      = sb_busy_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios then random traffic, all checked against
// a behavioural model of the pending-write set, register file and held bundle.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;

  operand_fetch_if bus();

  operand_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  assign bus.readDataA = rf[bus.readAddressA];
  assign bus.readDataB = rf[bus.readAddressB];

  int total = 0;
  int bad   = 0;

  // model: set of pending destinations plus the one bundle currently held
  logic [31:0] m_busy;
  bit          m_ov;
  logic [31:0] m_d1, m_d2, m_tag;
  logic [4:0]  m_rd;
  bit          m_rden;
  bit          seen_rdy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit pend(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(bus.wb_en && bus.wb_addr == r);
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_addr == r) return bus.wb_data;
    return rf[r];
  endfunction

  task automatic drive(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit rden, input logic [31:0] tag,
                       input bit ordy, input bit wben, input logic [4:0] wba,
                       input logic [31:0] wbd);
    bus.in_valid  = v;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_rd     = rd;
    bus.in_rd_en  = rden;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    bus.wb_en     = wben;
    bus.wb_addr   = wba;
    bus.wb_data   = wbd;
  endtask

  task automatic check_outputs();
    check_val("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
    check_val("sb_busy", bus.sb_busy, m_busy);
    if (m_ov) begin
      check_val("out_rs1_data", bus.out_rs1_data, m_d1);
      check_val("out_rs2_data", bus.out_rs2_data, m_d2);
      check_val("out_rd", {27'd0, bus.out_rd}, {27'd0, m_rd});
      check_val("out_rd_en", {31'd0, bus.out_rd_en}, {31'd0, m_rden});
      check_val("out_tag", bus.out_tag, m_tag);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check_val({tag, "_sb"}, bus.sb_busy, 32'd0);
    check_val({tag, "_d1"}, bus.out_rs1_data, 32'd0);
    check_val({tag, "_d2"}, bus.out_rs2_data, 32'd0);
    check_val({tag, "_rd"}, {27'd0, bus.out_rd}, 32'd0);
    check_val({tag, "_rden"}, {31'd0, bus.out_rd_en}, 32'd0);
    check_val({tag, "_tag"}, bus.out_tag, 32'd0);
    check_val({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
  endtask

  // one cycle: inputs already driven just after a rising edge
  task automatic step();
    bit adv, exp_rdy, acc, wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    #2;
    check_val("raddr_a", {27'd0, bus.readAddressA}, {27'd0, bus.in_rs1});
    check_val("raddr_b", {27'd0, bus.readAddressB}, {27'd0, bus.in_rs2});
    adv = !m_ov || bus.out_ready;
    exp_rdy = adv && !(bus.in_valid &&
              (pend(bus.in_rs1) || pend(bus.in_rs2) || (bus.in_rd_en && pend(bus.in_rd))));
    seen_rdy = bus.in_ready;
    check_val("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    acc = bus.in_valid && exp_rdy;
    if (adv) begin
      m_ov = acc;
      if (acc) begin
        m_d1   = opnd(bus.in_rs1);
        m_d2   = opnd(bus.in_rs2);
        m_rd   = bus.in_rd;
        m_rden = bus.in_rd_en;
        m_tag  = bus.in_tag;
      end
    end
    if (bus.wb_en && bus.wb_addr != 5'd0) m_busy[bus.wb_addr] = 1'b0;
    if (acc && bus.in_rd_en && bus.in_rd != 5'd0) m_busy[bus.in_rd] = 1'b1;
    wr = bus.wb_en && bus.wb_addr != 5'd0;
    wa = bus.wb_addr;
    wd = bus.wb_data;
    @(posedge clk);
    #1;
    if (wr) rf[wa] = wd;
    check_outputs();
  endtask

  task automatic model_reset();
    m_busy = '0;
    m_ov   = 1'b0;
    m_d1 = '0; m_d2 = '0; m_tag = '0; m_rd = '0; m_rden = 1'b0;
  endtask

  logic [31:0] snap_d1, snap_tag;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hBAD0_0000;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    check_reset_state("rst0");
    reset = 1'b0;

    // basic issue
    rf[3] = 32'h11;
    rf[4] = 32'h22;
    drive(1, 3, 4, 5, 1, 32'hA000_0001, 1, 0, 0, 0);
    step();
    check_val("b_d1", bus.out_rs1_data, 32'h11);
    check_val("b_d2", bus.out_rs2_data, 32'h22);
    check_val("b_rd", {27'd0, bus.out_rd}, 32'd5);
    check_val("b_sb", bus.sb_busy, 32'h20);

    // RAW stall on x5, released by same-cycle write-back with bypass
    drive(1, 5, 0, 0, 0, 32'hA000_0002, 1, 0, 0, 0);
    step();
    check_val("raw_stall", {31'd0, seen_rdy}, 32'd0);
    drive(1, 5, 0, 0, 0, 32'hA000_0002, 1, 1, 5, 32'hDEAD);
    step();
    check_val("raw_go", {31'd0, seen_rdy}, 32'd1);
    check_val("bypass_d1", bus.out_rs1_data, 32'hDEAD);
    check_val("x5_clear", {31'd0, bus.sb_busy[5]}, 32'd0);

    // backpressure hold
    drive(1, 1, 2, 0, 0, 32'hA000_0003, 1, 0, 0, 0);
    step();
    snap_d1  = bus.out_rs1_data;
    snap_tag = bus.out_tag;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2, 3, 0, 0, 32'hA000_0004, 0, 0, 0, 0);
      step();
      check_val("hold_rdy", {31'd0, seen_rdy}, 32'd0);
      check_val("hold_d1", bus.out_rs1_data, snap_d1);
      check_val("hold_tag", bus.out_tag, snap_tag);
    end
    drive(1, 2, 3, 0, 0, 32'hA000_0004, 1, 0, 0, 0);
    step();
    check_val("release_rdy", {31'd0, seen_rdy}, 32'd1);
    check_val("release_tag", bus.out_tag, 32'hA000_0004);

    // x0 destination and x0 write-back
    drive(1, 0, 0, 0, 1, 32'hA000_0005, 1, 1, 0, 32'hFFFF);
    step();
    check_val("x0_sb", bus.sb_busy, 32'd0);
    check_val("x0_d1", bus.out_rs1_data, 32'd0);

    // set wins over clear on x7
    drive(1, 0, 0, 7, 1, 32'hA000_0006, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 7, 1, 32'hA000_0007, 1, 1, 7, 32'h1234);
    step();
    check_val("waw_rdy", {31'd0, seen_rdy}, 32'd1);
    check_val("x7_set_wins", {31'd0, bus.sb_busy[7]}, 32'd1);

    // mid-operation async reset
    for (int r = 4; r <= 6; r++) begin
      drive(1, 0, 0, 5'(r), 1, 32'hB000_0000 + r, 1, 0, 0, 0);
      step();
    end
    check_val("pre_rst_sb", bus.sb_busy, 32'hF0);
    check_val("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_state("held_rst");
    reset = 1'b0;
    drive(1, 3, 4, 9, 1, 32'hC000_0001, 1, 0, 0, 0);
    step();
    check_val("post_rst_rdy", {31'd0, seen_rdy}, 32'd1);
    check_val("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom,
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
            5'($urandom_range(0, 7)), $urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: port clk is the clock and port reset is the reset, with no other clock or reset inputs.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  decoded instruction present.
REQ-005 in_ready  output  1  instruction accepted this cycle when high with in_valid.
REQ-006 in_rs1, in_rs2, in_rd  input  5 each  source and destination register indices.
REQ-007 in_rd_en  input  1  instruction writes in_rd.
REQ-008 in_tag  input  32  opaque payload (PC/immediate), passed through unchanged.
REQ-009 readAddressA, readAddressB  output  5 each  register-file read addresses.
REQ-010 readDataA, readDataB  input  32 each  combinational register-file read data.
REQ-011 wb_en, wb_addr, wb_data  input  1/5/32  snoop of the register-file write port (same-cycle values).
REQ-012 out_valid  output  1  operand bundle valid.
REQ-013 out_ready  input  1  downstream accepts the bundle.
REQ-014 out_rs1_data, out_rs2_data  output  32 each  resolved operands.
REQ-015 out_rd, out_rd_en, out_tag  output  5/1/32  registered copies of in_rd, in_rd_en, in_tag.
REQ-016 sb_busy  output  32  scoreboard; bit n high = write to xn pending.

Function
REQ-017 readAddressA SHALL equal in_rs1 and readAddressB SHALL equal in_rs2 combinationally.
REQ-018 x0 handling: index 0 is never busy, its operand is always 0, and in_rd_en with in_rd=0 does not mark the scoreboard.
REQ-019 Bypass: the operand for rsN SHALL be wb_data when wb_en=1, wb_addr=rsN, and rsN≠0; otherwise it SHALL be readDataA/B.
REQ-020 Hazard: hazard=1 when in_valid=1 and either of the following holds.
  - A source (rs1 or rs2, nonzero) has its sb_busy bit set and is not being cleared by a matching wb_en/wb_addr this cycle.
  - RAW/WAW: in_rd_en=1, in_rd≠0, sb_busy[in_rd]=1, and in_rd is not being cleared this cycle.
REQ-021 Output-register advance condition: can_advance = !out_valid || out_ready.
REQ-022 in_ready SHALL equal can_advance && !hazard. in_ready may depend on in_valid and in_rs/rd; out_valid SHALL NOT depend combinationally on in_valid.
REQ-023 Accept (in_valid && in_ready): at the next edge, out_valid=1 and the output register captures the REQ-019 operands plus rd/rd_en/tag. Latency is one cycle.
REQ-024 If can_advance=1 and no accept occurs, out_valid SHALL go 0 at the next edge.
REQ-025 While out_valid && !out_ready, all out_* outputs SHALL hold stable.
REQ-026 Scoreboard set: on accept with in_rd_en=1 and in_rd≠0, bit in_rd SHALL be set at the next edge.
REQ-027 Scoreboard clear: wb_en=1 with wb_addr≠0 SHALL clear bit wb_addr at the next edge.
REQ-028 Simultaneous set and clear of the same bit: set wins (the new pending writer).
REQ-029 A wb_en to a non-busy register SHALL be ignored by the scoreboard; data bypass per REQ-019 still applies.
REQ-030 Back-to-back accepts SHALL be supported at one per cycle while out_ready=1 and no hazard exists.

Reset
REQ-031 On reset assertion, immediately and independent of clk:
  - out_valid=0
  - sb_busy=0
  - out_rs1_data=0, out_rs2_data=0, out_rd=0, out_rd_en=0, out_tag=0
REQ-032 While reset=1, in_ready SHALL be 0.
REQ-033 Reset mid-operation SHALL discard the held bundle and all pending scoreboard bits. The first accept SHALL be possible in the first cycle after deassertion.

Verification
REQ-034 Reset, then issue rs1=3, rs2=4, rd=5, rd_en=1 with x3=0x11, x4=0x22 in the register file, out_ready=1 -> next cycle out_valid=1, out_rs1_data=0x11, out_rs2_data=0x22, out_rd=5, sb_busy=0x20.
REQ-035 With x5 busy, issue rs1=5 -> in_ready=0. Later, in the cycle with wb_en=1, wb_addr=5, wb_data=0xDEAD -> in_ready=1 that cycle; captured out_rs1_data=0xDEAD; sb_busy bit 5 cleared.
REQ-036 Hold out_ready=0 for 3 cycles with a bundle held -> out_* stable and in_ready=0; raise out_ready -> the next instruction is accepted that same cycle.
REQ-037 Issue rd=0, rd_en=1, rs1=0, with wb_en=1, wb_addr=0, wb_data=0xFFFF -> sb_busy unchanged and out_rs1_data=0.
REQ-038 With x7 busy, wb clears x7 while a new instruction with rd=7 is accepted in the same cycle -> sb_busy bit 7 remains 1.
REQ-039 Assert reset while out_valid=1 and sb_busy=0x0000_00F0 -> out_valid=0 and sb_busy=0 without a clock edge; an accept succeeds in the first cycle after release.
